gfx_raster_seq: RTL and testbench
=================================

// Module: gfx_raster_seq
// PURPOSE
//  Parametrised successor to the byte-command graphics sequencer. Accepts a byte command stream
//  ('P' point, 'L' line), collects operands and rasterises lines for all octants (Bresenham).
//  Emits one pixel per cycle on a valid/ready stream feeding the framebuffer writer.
// PARAMETERS
//  COORD_W   8    coordinate width, 8..16; each coordinate takes NB=(COORD_W+7)/8 bytes, LSB first
//  COLOR_W   8    colour width, 1..8; one colour byte, upper bits discarded
//  SCREEN_W  160  clip width, used only with GFX_CLIP_EN
//  SCREEN_H  120  clip height, used only with GFX_CLIP_EN
// PORTS
//  clk        in   1        clock; all state updates on posedge
//  rst_n      in   1        asynchronous, active-low reset
//  cmd_data   in   8        command/operand byte
//  cmd_valid  in   1        cmd_data valid
//  cmd_ready  out  1        byte accepted when cmd_valid && cmd_ready
//  pix_x      out  COORD_W  pixel x
//  pix_y      out  COORD_W  pixel y
//  pix_color  out  COLOR_W  pixel colour
//  pix_valid  out  1        pixel valid
//  pix_ready  in   1        sink accepts pixel when pix_valid && pix_ready
//  pix_last   out  1        qualifies the final emitted pixel of a command
//  busy       out  1        high in every state except IDLE
//  done       out  1        1-cycle pulse when a command completes
//  cmd_err    out  1        1-cycle pulse when an unknown opcode is received in IDLE
// BEHAVIOUR
//  Reset: state=IDLE. cmd_ready=1. pix_valid, pix_last, busy, done and cmd_err are 0.
//    pix_x, pix_y and pix_color are 0.
//  Reset mid-command abandons the command; partial operands are discarded.
//  IDLE: cmd_ready=1.
//    - 0x50 -> ARGS, operand count 2*NB+1 (X,Y,C).
//    - 0x4C -> ARGS, operand count 4*NB+1 (Xs,Ys,Xe,Ye,C).
//    - Any other byte is consumed, pulses cmd_err and stays in IDLE.
//  ARGS: cmd_ready=1; each accepted byte is stored; the byte counter decrements.
//    - Point: after the last byte -> EMIT with x=X, y=Y. pix_valid rises the cycle after that byte.
//    - Line: after the last byte -> SETUP (1 cycle), then DRAW.
//      First pixel is valid 2 cycles after the last byte.
//  SETUP computes, at width E=COORD_W+2 signed:
//    - dx=|Xe-Xs|, dy=-|Ye-Ys|, sx=(Xe>=Xs)?+1:-1, sy=(Ye>=Ys)?+1:-1, err=dx+dy.
//  DRAW: pix_valid=1 with the current (x,y).
//    - On handshake: if (x,y)==(Xe,Ye) -> DONE.
//    - Otherwise e2=2*err.
//      - If e2>=dy: x+=sx, err+=dy.
//      - If e2<=dx: y+=sy, err+=dx.
//      - Both tests use the pre-update err; both updates may apply in the same cycle.
//    - pix_ready low: pix_x, pix_y and pix_color hold stable and no step occurs.
//  pix_last=1 on the pixel where (x,y)==(Xe,Ye); for a point it is 1 on its only pixel.
//  Degenerate line (Xs,Ys)==(Xe,Ye): exactly one pixel with pix_last=1.
//  DONE (1 cycle): done=1 -> IDLE. cmd_ready=0 in SETUP, DRAW, EMIT and DONE.
//  Throughput: 1 pixel/clk while pix_ready=1. A line emits max(|dx|,|dy|)+1 pixels.
// CONFIGURATION
//  GFX_CLIP_EN defined:
//    - A pixel with x>=SCREEN_W or y>=SCREEN_H is suppressed.
//    - pix_valid stays 0 for that step, stepping continues one step/clk and no handshake is needed.
//    - If the final pixel is suppressed, no pix_last is seen, but done still pulses.
//  GFX_CLIP_EN undefined: every pixel is emitted; SCREEN_W and SCREEN_H are ignored.
// STRUCTURE
//  gfx_pkg holds:
//    - Opcode constants OP_POINT=8'h50 and OP_LINE=8'h4C.
//    - State enum IDLE, ARGS, SETUP, DRAW, EMIT, DONE.
//    - The NB/E width helper functions.
//  Sub-module gfx_line_stepper holds the Bresenham datapath:
//    - Inputs: load, step, endpoints.
//    - Outputs: x, y, at_end.
//  Operand capture, FSM and handshake stay in gfx_raster_seq.
// TESTING
//  1. Reset: rst_n=0 mid-line, release -> outputs reset; next 'P' command works cleanly.
//  2. Point: bytes 50,0A,14,07 -> one pixel (10,20,c=7) with pix_last, then done=1.
//     cmd_err=0 throughout.
//  3. Line octants: (0,0)->(5,2) gives 6 pixels:
//       (0,0),(1,0),(2,1),(3,1),(4,2),(5,2)
//     Repeat (5,2)->(0,0), steep (2,5)->(0,0) and horizontal/vertical cases; pixels match a reference model.
//  4. Backpressure: random pix_ready on a 20-pixel line -> same sequence, no drops or duplicates.
//     Outputs are stable while stalled.
//  5. Bad opcode: 0x33 in IDLE -> cmd_err pulse, stays IDLE; a following 'L' is accepted.
//  6. COORD_W=12 with GFX_CLIP_EN and SCREEN_W=160: line (150,0)->(170,0):
//     - 10 pixels emitted, none with pix_last.
//     - done pulses after x=170 is stepped.

Source files
------------

// File: rtl/gfx_pkg.sv
// gfx_pkg: shared definitions for the byte-command graphics sequencer.
//   OP_POINT / OP_LINE : command opcodes
//   state_e            : sequencer FSM states
//   nb_of / ew_of      : operand byte count per coordinate and Bresenham datapath width
package gfx_pkg;

  localparam logic [7:0] OP_POINT = 8'h50;
  localparam logic [7:0] OP_LINE  = 8'h4C;

  typedef enum logic [2:0] {IDLE, ARGS, SETUP, DRAW, EMIT, DONE} state_e;

  // Bytes per coordinate, sent LSB first.
  function automatic int unsigned nb_of(input int unsigned coord_w);
    return (coord_w + 7) / 8;
  endfunction

  // Signed width for dx/dy/err: coordinate width plus sign plus headroom.
  function automatic int unsigned ew_of(input int unsigned coord_w);
    return coord_w + 2;
  endfunction

endpackage

// File: rtl/gfx_line_stepper.sv
// gfx_line_stepper: Bresenham line datapath covering all octants.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   i_load               latch endpoints, compute dx/dy/sx/sy/err, set (x,y)=(xs,ys)
//   i_step               advance one Bresenham step
//   i_xs, i_ys, i_xe, i_ye  start and end coordinates (sampled on i_load)
//   o_x, o_y             current pixel
//   o_at_end             current pixel equals the end point
module gfx_line_stepper
  import gfx_pkg::*;
#(
  parameter int unsigned COORD_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_load,
  input  logic               i_step,
  input  logic [COORD_W-1:0] i_xs,
  input  logic [COORD_W-1:0] i_ys,
  input  logic [COORD_W-1:0] i_xe,
  input  logic [COORD_W-1:0] i_ye,
  output logic [COORD_W-1:0] o_x,
  output logic [COORD_W-1:0] o_y,
  output logic               o_at_end
);

  localparam int unsigned E = ew_of(COORD_W);

  logic [COORD_W-1:0] r_x, r_y, r_xe, r_ye;
  logic signed [E-1:0] r_dx, r_dy, r_err;
  logic                r_sx_neg, r_sy_neg;

  logic signed [E-1:0] w_ddx, w_ddy, w_dx0, w_dy0, w_err_d;
  logic signed [E:0]   w_e2, w_dx_ext, w_dy_ext;
  logic                w_mv_x, w_mv_y;

  // Setup values from the incoming endpoints; dy is kept negative.
  assign w_ddx = $signed({2'b00, i_xe}) - $signed({2'b00, i_xs});
  assign w_ddy = $signed({2'b00, i_ye}) - $signed({2'b00, i_ys});
  assign w_dx0 = w_ddx[E-1] ? -w_ddx : w_ddx;
  assign w_dy0 = w_ddy[E-1] ? w_ddy : -w_ddy;

  // One extra bit on e2 so 2*err never wraps.
  assign w_e2     = {r_err, 1'b0};
  assign w_dx_ext = {r_dx[E-1], r_dx};
  assign w_dy_ext = {r_dy[E-1], r_dy};
  assign w_mv_x   = (w_e2 >= w_dy_ext);
  assign w_mv_y   = (w_e2 <= w_dx_ext);
  assign w_err_d  = r_err + (w_mv_x ? r_dy : '0) + (w_mv_y ? r_dx : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x      <= '0;
      r_y      <= '0;
      r_xe     <= '0;
      r_ye     <= '0;
      r_dx     <= '0;
      r_dy     <= '0;
      r_err    <= '0;
      r_sx_neg <= 1'b0;
      r_sy_neg <= 1'b0;
    end else if (i_load) begin
      r_x      <= i_xs;
      r_y      <= i_ys;
      r_xe     <= i_xe;
      r_ye     <= i_ye;
      r_dx     <= w_dx0;
      r_dy     <= w_dy0;
      r_err    <= w_dx0 + w_dy0;
      r_sx_neg <= w_ddx[E-1];
      r_sy_neg <= w_ddy[E-1];
    end else if (i_step) begin
      if (w_mv_x) r_x <= r_sx_neg ? r_x - COORD_W'(1) : r_x + COORD_W'(1);
      if (w_mv_y) r_y <= r_sy_neg ? r_y - COORD_W'(1) : r_y + COORD_W'(1);
      r_err <= w_err_d;
    end
  end

  assign o_x      = r_x;
  assign o_y      = r_y;
  assign o_at_end = (r_x == r_xe) && (r_y == r_ye);

endmodule

// File: rtl/gfx_raster_seq.sv
// gfx_raster_seq: byte-command graphics sequencer ('P' point, 'L' line) with a
// one-pixel-per-clock valid/ready pixel stream.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   cmd_data/cmd_valid/cmd_ready    command and operand byte stream
//   pix_x/pix_y/pix_color           pixel coordinate and colour
//   pix_valid/pix_ready/pix_last    pixel handshake; pix_last marks the end point
//   busy                            any state other than IDLE
//   done                            1-cycle pulse when a command completes
//   cmd_err                         1-cycle pulse on an unknown opcode
// Build option: define GFX_CLIP_EN to suppress pixels outside SCREEN_W x SCREEN_H.
module gfx_raster_seq
  import gfx_pkg::*;
#(
  parameter int unsigned COORD_W  = 8,
  parameter int unsigned COLOR_W  = 8,
  parameter int unsigned SCREEN_W = 160,
  parameter int unsigned SCREEN_H = 120
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         cmd_data,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic [COLOR_W-1:0] pix_color,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic               pix_last,
  output logic               busy,
  output logic               done,
  output logic               cmd_err
);

  localparam int unsigned NB       = nb_of(COORD_W);
  localparam int unsigned NBYTES_P = 2 * NB + 1;
  localparam int unsigned NBYTES_L = 4 * NB + 1;

  if (COORD_W < 8 || COORD_W > 16 || COLOR_W < 1 || COLOR_W > 8 ||
      SCREEN_W == 0 || SCREEN_H == 0) begin : g_bad_param
    $error("gfx_raster_seq: parameter out of range");
  end

  state_e             r_state;
  logic [3:0]         r_cnt;
  logic [3:0]         r_idx;
  logic               r_is_line;
  logic [COORD_W-1:0] r_crd [4];  // Xs, Ys, Xe, Ye (point uses Xs, Ys)
  logic [COLOR_W-1:0] r_color;
  logic               r_cmd_ready, r_busy, r_done, r_cmd_err;
  logic               r_emit;     // in DRAW or EMIT

  logic               w_accept, w_last, w_load, w_adv, w_step, w_clip;
  logic [COORD_W-1:0] w_x, w_y, w_xe, w_ye;
  logic               w_at_end;

  assign w_accept = cmd_valid && r_cmd_ready;
  assign w_last   = (r_cnt == 4'd1);

  // A point is a degenerate line; it is loaded straight from ARGS so its pixel
  // is valid the cycle after the colour byte. Lines load during SETUP.
  assign w_load = ((r_state == ARGS) && w_accept && w_last && !r_is_line) ||
                  (r_state == SETUP);
  assign w_xe   = r_is_line ? r_crd[2] : r_crd[0];
  assign w_ye   = r_is_line ? r_crd[3] : r_crd[1];

`ifdef GFX_CLIP_EN
  assign w_clip = (32'(w_x) >= SCREEN_W) || (32'(w_y) >= SCREEN_H);
`else
  assign w_clip = 1'b0;
`endif

  // Clipped pixels advance without a handshake.
  assign w_adv  = r_emit && (pix_ready || w_clip);
  assign w_step = w_adv && !w_at_end;

  gfx_line_stepper #(
    .COORD_W (COORD_W)
  ) u_stepper (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_load),
    .i_step   (w_step),
    .i_xs     (r_crd[0]),
    .i_ys     (r_crd[1]),
    .i_xe     (w_xe),
    .i_ye     (w_ye),
    .o_x      (w_x),
    .o_y      (w_y),
    .o_at_end (w_at_end)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_is_line   <= 1'b0;
      for (int f = 0; f < 4; f++) r_crd[f] <= '0;
      r_color     <= '0;
      r_cmd_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_cmd_err   <= 1'b0;
      r_emit      <= 1'b0;
    end else begin
      r_cmd_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (cmd_data == OP_POINT || cmd_data == OP_LINE) begin
              r_state   <= ARGS;
              r_busy    <= 1'b1;
              r_is_line <= (cmd_data == OP_LINE);
              r_cnt     <= (cmd_data == OP_LINE) ? 4'(NBYTES_L) : 4'(NBYTES_P);
              r_idx     <= '0;
            end else begin
              r_cmd_err <= 1'b1;
            end
          end
        end
        ARGS: begin
          if (w_accept) begin
            r_cnt <= r_cnt - 4'd1;
            r_idx <= r_idx + 4'd1;
            if (w_last) begin
              // Final byte is always the colour; upper bits are dropped.
              r_color     <= cmd_data[COLOR_W-1:0];
              r_cmd_ready <= 1'b0;
              if (r_is_line) begin
                r_state <= SETUP;
              end else begin
                r_state <= EMIT;
                r_emit  <= 1'b1;
              end
            end else begin
              // Byte idx holds bits [8*(idx%NB) +: 8] of coordinate idx/NB.
              for (int f = 0; f < 4; f++) begin
                for (int i = 0; i < int'(COORD_W); i++) begin
                  if (r_idx == 4'(f * int'(NB) + i / 8)) r_crd[f][i] <= cmd_data[i % 8];
                end
              end
            end
          end
        end
        SETUP: begin
          r_state <= DRAW;
          r_emit  <= 1'b1;
        end
        DRAW, EMIT: begin
          if (w_adv && w_at_end) begin
            r_state <= DONE;
            r_emit  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_state     <= IDLE;
          r_done      <= 1'b0;
          r_busy      <= 1'b0;
          r_cmd_ready <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign busy      = r_busy;
  assign done      = r_done;
  assign cmd_err   = r_cmd_err;
  assign pix_x     = w_x;
  assign pix_y     = w_y;
  assign pix_color = r_color;
  assign pix_valid = r_emit && !w_clip;
  assign pix_last  = pix_valid && w_at_end;

endmodule

// File: tb/tb_gfx_raster_seq.sv
// Self-checking bench for gfx_raster_seq: fixed and random points/lines compared
// against a plain-arithmetic Bresenham reference, with random sink backpressure.
module tb_gfx_raster_seq;

`ifdef GFX_CLIP_EN
  localparam int unsigned CW = 12;
`else
  localparam int unsigned CW = 8;
`endif
  localparam int unsigned KW = 8;
  localparam int SW = 160;
  localparam int SH = 120;
  localparam int NB = (CW + 7) / 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    cmd_data = 8'h00;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [CW-1:0] pix_x, pix_y;
  logic [KW-1:0] pix_color;
  logic          pix_valid, pix_last, busy, done, cmd_err;
  logic          pix_ready = 1'b1;

  always #5 clk = ~clk;

  gfx_raster_seq #(
    .COORD_W  (CW),
    .COLOR_W  (KW),
    .SCREEN_W (SW),
    .SCREEN_H (SH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_data  (cmd_data),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_color (pix_color),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_last  (pix_last),
    .busy      (busy),
    .done      (done),
    .cmd_err   (cmd_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- monitor ----------------
  logic [15:0] cap_x[$], cap_y[$];
  logic [7:0]  cap_c[$];
  logic        cap_l[$];
  int          n_done = 0;
  int          n_err = 0;
  bit          bp_en = 1'b0;
  logic        prev_stall = 1'b0;
  logic [63:0] prev_pix = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall)
        check_eq("stall_hold", 64'({pix_valid, pix_x, pix_y, pix_color}), prev_pix);
      if (pix_valid && pix_ready) begin
        cap_x.push_back(16'(pix_x));
        cap_y.push_back(16'(pix_y));
        cap_c.push_back(8'(pix_color));
        cap_l.push_back(pix_last);
      end
      if (done) n_done++;
      if (cmd_err) n_err++;
      prev_stall = pix_valid && !pix_ready;
      prev_pix   = 64'({pix_valid, pix_x, pix_y, pix_color});
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    pix_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // ---------------- reference model ----------------
  int exp_x[$], exp_y[$];
  bit exp_l[$];

  function automatic bit clipped(input int x, input int y);
`ifdef GFX_CLIP_EN
    return (x >= SW) || (y >= SH);
`else
    return (x < 0) || (y < 0);
`endif
  endfunction

  task automatic gen_ref(input int xs, input int ys, input int xe, input int ye);
    int x = xs, y = ys;
    int dx = (xe > xs) ? xe - xs : xs - xe;
    int dy = (ye > ys) ? ys - ye : ye - ys;
    int sx = (xe >= xs) ? 1 : -1;
    int sy = (ye >= ys) ? 1 : -1;
    int err = dx + dy;
    int e2;
    exp_x.delete(); exp_y.delete(); exp_l.delete();
    for (int k = 0; k < 100000; k++) begin
      if (!clipped(x, y)) begin
        exp_x.push_back(x);
        exp_y.push_back(y);
        exp_l.push_back((x == xe) && (y == ye));
      end
      if (x == xe && y == ye) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
  endtask

  // ---------------- stimulus ----------------
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    cmd_data  = b;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check_eq("cmd_ready_timeout", 64'(cmd_ready), 64'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic send_coord(input int v);
    for (int b = 0; b < NB; b++) send_byte(8'(v >> (8 * b)));
  endtask

  task automatic run_cmd(input bit is_line, input int xs, input int ys, input int xe,
                         input int ye, input logic [7:0] c, input string tag);
    int d0, e0, n, len, adx, ady;
    cap_x.delete(); cap_y.delete(); cap_c.delete(); cap_l.delete();
    d0 = n_done;
    e0 = n_err;
    if (is_line) gen_ref(xs, ys, xe, ye);
    else gen_ref(xs, ys, xs, ys);
    send_byte(is_line ? 8'h4C : 8'h50);
    send_coord(xs);
    send_coord(ys);
    if (is_line) begin
      send_coord(xe);
      send_coord(ye);
    end
    send_byte(c);
    @(negedge clk);
    if (is_line) begin
      check_eq({tag, "_lat_setup"}, 64'(pix_valid), 64'd0);
      @(negedge clk);
    end
    check_eq({tag, "_lat_first"}, 64'(pix_valid), 64'(!clipped(xs, ys)));
    n = 0;
    while (n_done == d0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check_eq({tag, "_done"}, 64'(n_done - d0), 64'd1);
    check_eq({tag, "_err"}, 64'(n_err - e0), 64'd0);
    check_eq({tag, "_busy"}, 64'(busy), 64'd0);
    check_eq({tag, "_count"}, 64'(cap_x.size()), 64'(exp_x.size()));
`ifndef GFX_CLIP_EN
    adx = (xe > xs) ? xe - xs : xs - xe;
    ady = (ye > ys) ? ye - ys : ys - ye;
    len = is_line ? ((adx > ady) ? adx : ady) + 1 : 1;
    check_eq({tag, "_len"}, 64'(cap_x.size()), 64'(len));
`endif
    for (int i = 0; i < cap_x.size() && i < exp_x.size(); i++)
      check_eq({tag, "_pix"}, 64'({cap_x[i], cap_y[i], cap_c[i], cap_l[i]}),
               64'({16'(exp_x[i]), 16'(exp_y[i]), c, exp_l[i]}));
  endtask

  int fl[8][4] = '{'{0, 0, 5, 2}, '{5, 2, 0, 0}, '{2, 5, 0, 0}, '{0, 0, 2, 5},
                   '{0, 3, 9, 3}, '{4, 9, 4, 1}, '{7, 7, 7, 7}, '{9, 0, 0, 6}};
  int lit_y[6] = '{0, 0, 1, 1, 2, 2};

  initial begin
    int e0, nl;
    // Reset state
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_ready", 64'(cmd_ready), 64'd1);
    check_eq("rst_flags", 64'({pix_valid, pix_last, busy, done, cmd_err}), 64'd0);
    check_eq("rst_pix", 64'({pix_x, pix_y, pix_color}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Point
    run_cmd(1'b0, 10, 20, 0, 0, 8'h07, "point");
    if (cap_x.size() > 0)
      check_eq("point_lit", 64'({cap_x[0], cap_y[0], cap_c[0], cap_l[0]}),
               64'({16'd10, 16'd20, 8'd7, 1'b1}));

    // Fixed octant / axis / degenerate lines
    for (int i = 0; i < 8; i++)
      run_cmd(1'b1, fl[i][0], fl[i][1], fl[i][2], fl[i][3], 8'($urandom), "oct");
    run_cmd(1'b1, 0, 0, 5, 2, 8'h3C, "lit52");
    for (int i = 0; i < 6 && i < cap_x.size(); i++)
      check_eq("lit52_xy", 64'({cap_x[i], cap_y[i]}), 64'({16'(i), 16'(lit_y[i])}));

    // Random lines and points
    for (int i = 0; i < 10; i++)
      run_cmd(1'b1, $urandom_range(0, 40), $urandom_range(0, 40), $urandom_range(0, 40),
              $urandom_range(0, 40), 8'($urandom), "rnd");
    for (int i = 0; i < 3; i++)
      run_cmd(1'b0, $urandom_range(0, 100), $urandom_range(0, 100), 0, 0, 8'($urandom), "rpt");

    // Backpressure
    bp_en = 1'b1;
    run_cmd(1'b1, 0, 0, 19, 7, 8'h5A, "bp20");
    check_eq("bp20_n", 64'(cap_x.size()), 64'd20);
    run_cmd(1'b1, 30, 2, 3, 25, 8'hA5, "bprnd");
    bp_en = 1'b0;

    // Bad opcode
    e0 = n_err;
    send_byte(8'h33);
    repeat (2) @(negedge clk);
    check_eq("bad_err", 64'(n_err - e0), 64'd1);
    check_eq("bad_idle", 64'({busy, cmd_ready}), 64'b01);
    run_cmd(1'b1, 3, 1, 8, 6, 8'h11, "after_bad");

    // Reset mid-line, then a clean point
    send_byte(8'h4C);
    send_coord(0); send_coord(0); send_coord(60); send_coord(30);
    send_byte(8'h22);
    repeat (10) @(negedge clk);
    check_eq("mid_busy", 64'({busy, pix_valid}), 64'b11);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_flags", 64'({cmd_ready, pix_valid, pix_last, busy, done, cmd_err}),
             64'b100000);
    check_eq("mid_rst_pix", 64'({pix_x, pix_y, pix_color}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_cmd(1'b0, 3, 4, 0, 0, 8'h09, "post_rst");

`ifdef GFX_CLIP_EN
    // Line crossing the right clip edge
    run_cmd(1'b1, 150, 0, 170, 0, 8'h44, "clip");
    check_eq("clip_n", 64'(cap_x.size()), 64'd10);
    nl = 0;
    foreach (cap_l[i]) if (cap_l[i]) nl++;
    check_eq("clip_nolast", 64'(nl), 64'd0);
`else
    nl = 0;
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
